// File: rtl/param_wb_cache_pkg.sv
// Shared types for the parametrised write-back cache: FSM state encoding,
// statistics counter width and a saturating-increment helper.
// Optional statistics are enabled with the CACHE_STATS_EN macro.
package param_wb_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WBACK = 2'd1,
    ST_FILL  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int STAT_W = 32;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/param_wb_cache_line_store.sv
// Purpose: line storage for the cache: data words, per-line tag, valid and dirty.
// Latency: combinational read, write takes effect at the next rising clk_i.
// Backpressure: none; the owning FSM serialises every access.
// Ports: rd_index_i/rd_offset_i -> rd_data_o/rd_tag_o/rd_valid_o/rd_dirty_o;
//        wr_en_i writes one data word at {wr_index_i,wr_offset_i};
//        meta_we_i sets line wr_index_i valid with meta_tag_i/meta_dirty_i.
module param_wb_cache_line_store
  import param_wb_cache_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2,
  parameter int TAG_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [INDEX_W-1:0]  rd_index_i,
  input  logic [OFFSET_W-1:0] rd_offset_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  input  logic                wr_en_i,
  input  logic [INDEX_W-1:0]  wr_index_i,
  input  logic [OFFSET_W-1:0] wr_offset_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                meta_we_i,
  input  logic [TAG_W-1:0]    meta_tag_i,
  input  logic                meta_dirty_i
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFSET_W);

  logic [DATA_W-1:0] data_q [WORDS];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;

  assign rd_data_o  = data_q[{rd_index_i, rd_offset_i}];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_dirty_o = dirty_q[rd_index_i];

  // Data and tags are never cleared; valid gates their use.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[{wr_index_i, wr_offset_i}] <= wr_data_i;
    end
    if (meta_we_i) begin
      tag_q[wr_index_i] <= meta_tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we_i) begin
      valid_q[wr_index_i] <= 1'b1;
      dirty_q[wr_index_i] <= meta_dirty_i;
    end
  end

endmodule

// File: rtl/param_wb_cache.sv
// Purpose: direct-mapped write-back, write-allocate cache with multi-word lines.
// Latency: hit -> cpu_ready 1 cycle after the request cycle; miss -> memory handshakes + 2.
// Backpressure: cpu_req is held until cpu_ready; mem_req is held until mem_ack.
// Ports: clk_25mhz, rst_n (async, active low); CPU side cpu_req/cpu_we/cpu_addr/
//   cpu_wdata -> cpu_rdata/cpu_ready; RAM side mem_req/mem_we/mem_addr/mem_wdata
//   <- mem_rdata/mem_ack. With CACHE_STATS_EN defined: stat_hits/stat_misses/stat_wbacks.
// TAG_W = ADDR_W-INDEX_W-OFFSET_W must be at least 1.
module param_wb_cache
  import param_wb_cache_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 16,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic              clk_25mhz,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_misses,
  output logic [STAT_W-1:0] stat_wbacks
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  // Request address fields.
  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  assign req_tag = cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_idx = cpu_addr[OFFSET_W +: INDEX_W];
  assign req_off = cpu_addr[OFFSET_W-1:0];

  // Registered state and latched request.
  state_e              state_q;
  logic                we_q;
  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [OFFSET_W-1:0] off_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [TAG_W-1:0]    vtag_q;
  logic [OFFSET_W-1:0] cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  // Line store interface.
  logic [INDEX_W-1:0]  st_rd_idx;
  logic [OFFSET_W-1:0] st_rd_off;
  logic [DATA_W-1:0]   st_rdata;
  logic [TAG_W-1:0]    st_tag;
  logic                st_valid;
  logic                st_dirty;
  logic                st_wr_en;
  logic [OFFSET_W-1:0] st_wr_off;
  logic [DATA_W-1:0]   st_wr_data;
  logic                st_meta_we;
  logic                st_meta_dirty;

  logic hit;
  logic last;
  logic mem_hs;
  logic fill_ack;
  logic wback_ack;
  logic resp_wr;

  // In IDLE the store is looked up with the incoming address; elsewhere the
  // burst counter walks the latched line.
  assign st_rd_idx = (state_q == ST_IDLE) ? req_idx : idx_q;
  assign st_rd_off = (state_q == ST_IDLE) ? req_off : cnt_q;

  assign hit       = st_valid && (st_tag == req_tag);
  assign last      = &cnt_q;
  assign mem_hs    = mem_req_q && mem_ack;
  assign fill_ack  = (state_q == ST_FILL) && mem_hs;
  assign wback_ack = (state_q == ST_WBACK) && mem_hs;
  assign resp_wr   = (state_q == ST_RESP) && we_q;

  // Fill words and the CPU write merge land in different cycles, so one
  // write port serves both; the merge always follows the fill of its line.
  assign st_wr_en      = fill_ack || resp_wr;
  assign st_wr_off     = resp_wr ? off_q : cnt_q;
  assign st_wr_data    = resp_wr ? wdata_q : mem_rdata;
  assign st_meta_we    = (fill_ack && last) || resp_wr;
  assign st_meta_dirty = resp_wr;

  param_wb_cache_line_store #(
    .DATA_W  (DATA_W),
    .INDEX_W (INDEX_W),
    .OFFSET_W(OFFSET_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk_i       (clk_25mhz),
    .rst_ni      (rst_n),
    .rd_index_i  (st_rd_idx),
    .rd_offset_i (st_rd_off),
    .rd_data_o   (st_rdata),
    .rd_tag_o    (st_tag),
    .rd_valid_o  (st_valid),
    .rd_dirty_o  (st_dirty),
    .wr_en_i     (st_wr_en),
    .wr_index_i  (idx_q),
    .wr_offset_i (st_wr_off),
    .wr_data_i   (st_wr_data),
    .meta_we_i   (st_meta_we),
    .meta_tag_i  (tag_q),
    .meta_dirty_i(st_meta_dirty)
  );

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      tag_q       <= '0;
      idx_q       <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      vtag_q      <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req) begin
            we_q    <= cpu_we;
            tag_q   <= req_tag;
            idx_q   <= req_idx;
            off_q   <= req_off;
            wdata_q <= cpu_wdata;
            vtag_q  <= st_tag;
            cnt_q   <= '0;
            if (hit) begin
              rdata_q <= st_rdata;
              ready_q <= 1'b1;
              state_q <= ST_RESP;
            end else if (st_valid && st_dirty) begin
              state_q <= ST_WBACK;
            end else begin
              state_q <= ST_FILL;
            end
          end
        end
        ST_WBACK: begin
          if (mem_req_q) begin
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              cnt_q     <= cnt_q + 1'b1;   // wraps to 0 for the fill
              if (last) begin
                state_q <= ST_FILL;
              end
            end
          end else begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {vtag_q, idx_q, cnt_q};
            mem_wdata_q <= st_rdata;
          end
        end
        ST_FILL: begin
          if (mem_req_q) begin
            if (mem_ack) begin
              mem_req_q <= 1'b0;
              cnt_q     <= cnt_q + 1'b1;
              if (cnt_q == off_q) begin
                rdata_q <= mem_rdata;
              end
              if (last) begin
                ready_q <= 1'b1;
                state_q <= ST_RESP;
              end
            end
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag_q, idx_q, cnt_q};
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hits_q;
  logic [STAT_W-1:0] misses_q;
  logic [STAT_W-1:0] wbacks_q;

  // Misses and write-backs count when their burst completes.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbacks_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && cpu_req && hit) begin
        hits_q <= sat_inc(hits_q);
      end
      if (fill_ack && last) begin
        misses_q <= sat_inc(misses_q);
      end
      if (wback_ack && last) begin
        wbacks_q <= sat_inc(wbacks_q);
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_wbacks = wbacks_q;
`endif

endmodule

// File: tb/tb_param_wb_cache.sv
// Bench for param_wb_cache (default parameters): directed scenarios plus random
// traffic, scored against a flat coherent memory image and a line directory.
module tb_param_wb_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_wbacks;
`endif

  param_wb_cache dut (
    .clk_25mhz(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
`endif
  );

  always #20 clk = ~clk;

  typedef struct { logic we; logic [31:0] data; logic hit; } cexp_t;
  typedef struct { logic we; logic [15:0] addr; logic [31:0] data; } mexp_t;

  cexp_t cpu_exp[$];
  mexp_t mem_exp[$];

  logic [31:0] ram     [65536];   // the RAM behind the cache
  logic [31:0] ref_mem [65536];   // what the CPU must observe
  logic [7:0]  m_tag   [64];
  logic        m_valid [64];
  logic        m_dirty [64];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int req_cyc = 0;
  int rd_acks = 0;
  int wcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RAM model: acks two cycles after seeing mem_req, occasionally pulses a stray
  // ack while idle, and scores every accepted word against the expected burst.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req) begin
      wcnt++;
      if (wcnt >= 2) begin
        wcnt = 0;
        mem_ack = 1'b1;
        mem_rdata = ram[mem_addr];
        if (mem_we) ram[mem_addr] = mem_wdata;
        else rd_acks++;
        if (mem_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected: got addr %h we %0d want no traffic", mem_addr, mem_we);
        end else begin
          mexp_t m;
          m = mem_exp.pop_front();
          chk("mem_addr", {16'h0, mem_addr}, {16'h0, m.addr});
          chk("mem_we", {31'h0, mem_we}, {31'h0, m.we});
          if (m.we) chk("mem_wdata", mem_wdata, m.data);
        end
      end
    end else if ($urandom_range(0, 7) == 0) begin
      mem_ack = 1'b1;
      mem_rdata = $urandom;
    end
  end

  // CPU-side monitor.
  always @(negedge clk) begin
    if (rst_n && cpu_ready) begin
      if (cpu_exp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cpu_unexpected: got cpu_ready=1 want no response");
      end else begin
        cexp_t e;
        e = cpu_exp.pop_front();
        if (!e.we) chk("cpu_rdata", cpu_rdata, e.data);
        if (e.hit) chk("hit_latency", cyc - req_cyc, 1);
        else begin
          checks++;
          if (cyc - req_cyc < 3) begin
            errors++;
            $display("FAIL miss_latency: got %0d want >=3", cyc - req_cyc);
          end
        end
      end
    end
  end

  // Predict the response and memory traffic from the cache's visible rules.
  task automatic predict(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
    int idx = int'(addr[7:2]);
    logic [7:0] tag = addr[15:8];
    cexp_t e;
    mexp_t m;
    e.hit = m_valid[idx] && (m_tag[idx] == tag);
    e.we = we;
    if (!e.hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int k = 0; k < 4; k++) begin
          m.we = 1'b1;
          m.addr = {m_tag[idx], addr[7:2], 2'(k)};
          m.data = ref_mem[m.addr];
          mem_exp.push_back(m);
        end
      end
      for (int k = 0; k < 4; k++) begin
        m.we = 1'b0;
        m.addr = {tag, addr[7:2], 2'(k)};
        m.data = '0;
        mem_exp.push_back(m);
      end
      m_valid[idx] = 1'b1;
      m_tag[idx] = tag;
      m_dirty[idx] = 1'b0;
    end
    if (we) begin
      ref_mem[addr] = wdata;
      m_dirty[idx] = 1'b1;
    end
    e.data = ref_mem[addr];
    cpu_exp.push_back(e);
  endtask

  task automatic do_access(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
    bit done = 0;
    predict(we, addr, wdata);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    req_cyc = cyc;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (cpu_ready) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cpu_timeout: got no cpu_ready for addr %h want response", addr);
    end
    cpu_req = 1'b0;
  endtask

  task automatic flush_model();
    mem_exp.delete();
    cpu_exp.delete();
    for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end
    for (int i = 0; i < 65536; i++) ref_mem[i] = ram[i];
  endtask

  task automatic check_idle_outputs(input string tagname);
    chk({tagname, "_cpu_ready"}, {31'h0, cpu_ready}, 32'h0);
    chk({tagname, "_mem_req"}, {31'h0, mem_req}, 32'h0);
    chk({tagname, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    chk({tagname, "_mem_addr"}, {16'h0, mem_addr}, 32'h0);
    chk({tagname, "_cpu_rdata"}, cpu_rdata, 32'h0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: got no completion want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit_word2;
    int base;
    for (int i = 0; i < 65536; i++) ram[i] = $urandom;
    ram[4] = 32'h80200001; ram[5] = 32'hE8200000;
    ram[6] = 32'h80400002; ram[7] = 32'hE8400001;
    flush_model();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Cold read, then a repeat that must hit.
    do_access(0, 16'h0005, '0);
    do_access(0, 16'h0005, '0);
    // Write hit stays in the cache.
    do_access(1, 16'h0005, 32'hDEADBEEF);
    chk("ram5_after_write_hit", ram[5], 32'hE8200000);
    do_access(0, 16'h0005, '0);
    // Conflict miss forces the dirty line out.
    do_access(0, 16'h0105, '0);
    chk("ram5_after_wback", ram[5], 32'hDEADBEEF);
    // Write miss onto an invalid line, then evict it.
    do_access(1, 16'h0200, 32'h12345678);
    do_access(0, 16'h0000, '0);
    chk("ram200_after_evict", ram[16'h0200], 32'h12345678);

    // Reset while the third fill word is outstanding.
    predict(0, 16'h0005, '0);
    base = rd_acks;
    hit_word2 = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005; req_cyc = cyc;
    for (int n = 0; n < 200 && !hit_word2; n++) begin
      @(negedge clk);
      #1;
      if (rd_acks - base == 2 && mem_req && !mem_ack) hit_word2 = 1;
    end
    chk("reached_fill_word2", {31'h0, hit_word2}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_fill_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mid_fill_cpu_ready", {31'h0, cpu_ready}, 32'h0);
    cpu_req = 1'b0;
    flush_model();
    repeat (3) @(negedge clk);
    check_idle_outputs("rst2");
    rst_n = 1'b1;
    do_access(0, 16'h0005, '0);   // must miss again and see the written-back word

    // Top-of-address-space line: fill and write-back must not carry into the tag.
    do_access(1, 16'hFFFF, 32'hCAFEF00D);
    do_access(0, 16'hFFFC, '0);
    do_access(0, 16'h00FC, '0);
    chk("ramFFFF_after_evict", ram[16'hFFFF], 32'hCAFEF00D);

    // Random traffic over a few tags and indices to provoke conflicts.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] tg;
      logic [15:0] a;
      case ($urandom_range(0, 3))
        0: tg = 8'h00;
        1: tg = 8'h01;
        2: tg = 8'h02;
        default: tg = 8'hFF;
      endcase
      a = {tg, 6'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      do_access(1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("cpu_exp_drained", cpu_exp.size(), 0);
    chk("mem_exp_drained", mem_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
